// File: rtl/inst_buf_rename_skid_pkg.sv
// Shared decode-side types for the instruction-buffer-to-rename skid stage.
// Build option: define INST_BUF_REN_LANE_GATE_EN to add per-lane activity gating.
package inst_buf_rename_skid_pkg;

  localparam int REN_PKT_SIZE   = 128;
  localparam int DISPATCH_WIDTH = 4;

  typedef logic [REN_PKT_SIZE-1:0] ren_pkt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/inst_buf_rename_skid_entry.sv
// One bundle slot of the skid buffer: per-lane packet registers plus lane valids.
// Packet slices only clock on a lane-enabled load; clear wipes valids only.
module inst_buf_rename_skid_entry
  import inst_buf_rename_skid_pkg::*;
#(
  parameter int LANES = DISPATCH_WIDTH,
  parameter int PKT_W = REN_PKT_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   clr_i,
  input  logic [LANES-1:0]       lane_ld_i,
  input  logic [LANES*PKT_W-1:0] pkt_i,
  input  logic [LANES-1:0]       vld_i,
  output logic [LANES*PKT_W-1:0] pkt_o,
  output logic [LANES-1:0]       vld_o
);

  logic [LANES-1:0] vld_d, vld_q;
  logic [PKT_W-1:0] pkt_d [LANES];
  logic [PKT_W-1:0] pkt_q [LANES];

  always_comb begin
    vld_d = vld_q;
    if (clr_i)       vld_d = '0;
    else if (load_i) vld_d = vld_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pkt_d[i] = pkt_i[i*PKT_W +: PKT_W];

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                        pkt_q[i] <= '0;
      else if (load_i && lane_ld_i[i])  pkt_q[i] <= pkt_d[i];
    end

    assign pkt_o[i*PKT_W +: PKT_W] = pkt_q[i];
  end

  assign vld_o = vld_q;

endmodule

// File: rtl/inst_buf_rename_skid.sv
// Two-entry skid stage between instruction buffer and rename; 1-cycle latency, registered up_ready.
// Optional INST_BUF_REN_LANE_GATE_EN adds lane_active_i / valid_bundle_o for dynamic dispatch width.
module inst_buf_rename_skid
  import inst_buf_rename_skid_pkg::*;
#(
  parameter int LANES        = DISPATCH_WIDTH,
  parameter int PKT_W        = REN_PKT_SIZE,
  parameter int SQUASH_EMPTY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   up_valid_i,
  output logic                   up_ready_o,
  input  logic [LANES*PKT_W-1:0] pkt_i,
  input  logic [LANES-1:0]       lane_valid_i,
  output logic                   dn_valid_o,
  input  logic                   dn_ready_i,
  output logic [LANES*PKT_W-1:0] pkt_o,
  output logic [LANES-1:0]       lane_valid_o,
  output logic [1:0]             occupancy_o
`ifdef INST_BUF_REN_LANE_GATE_EN
  ,
  input  logic [LANES-1:0]       lane_active_i,
  output logic [LANES-1:0]       valid_bundle_o
`endif
);

  logic [LANES-1:0] act;

`ifdef INST_BUF_REN_LANE_GATE_EN
  assign act            = lane_active_i;
  assign valid_bundle_o = {LANES{up_valid_i}} & lane_valid_i & lane_active_i;
`else
  assign act = '1;
`endif

  skid_state_t state_d, state_q;
  logic        up_ready_d, up_ready_q;
  logic        up_fire, dn_fire, enq;
  logic [LANES-1:0] in_vld;
  logic        head_ld_in, head_ld_skid, skid_ld, clr;

  logic [LANES*PKT_W-1:0] head_pkt, skid_pkt, head_pkt_in;
  logic [LANES-1:0]       head_vld, skid_vld, head_vld_in, head_lane_ld;

  assign in_vld     = lane_valid_i & act;
  assign up_fire    = up_valid_i & up_ready_q;
  assign dn_valid_o = (state_q != EMPTY) & ~flush_i;
  assign dn_fire    = dn_valid_o & dn_ready_i;
  // All-invalid bundles are still consumed upstream, just never stored.
  assign enq        = up_fire & ((|in_vld) | (SQUASH_EMPTY == 0));

  always_comb begin
    state_d      = state_q;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    clr          = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
      clr     = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (enq) begin
          state_d    = HALF;
          head_ld_in = 1'b1;
        end
        HALF: begin
          if (enq && dn_fire) begin
            head_ld_in = 1'b1;
          end else if (enq) begin
            state_d = FULL;
            skid_ld = 1'b1;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (dn_fire) begin
          state_d      = HALF;
          head_ld_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
    up_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      up_ready_q <= up_ready_d;
    end
  end

  assign head_pkt_in  = head_ld_skid ? skid_pkt : pkt_i;
  assign head_vld_in  = head_ld_skid ? skid_vld : in_vld;
  assign head_lane_ld = head_ld_skid ? {LANES{1'b1}} : act;

  inst_buf_rename_skid_entry #(.LANES(LANES), .PKT_W(PKT_W)) u_head (
    .clk       (clk),
    .reset     (reset),
    .load_i    (head_ld_in | head_ld_skid),
    .clr_i     (clr),
    .lane_ld_i (head_lane_ld),
    .pkt_i     (head_pkt_in),
    .vld_i     (head_vld_in),
    .pkt_o     (head_pkt),
    .vld_o     (head_vld)
  );

  inst_buf_rename_skid_entry #(.LANES(LANES), .PKT_W(PKT_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load_i    (skid_ld),
    .clr_i     (clr),
    .lane_ld_i (act),
    .pkt_i     (pkt_i),
    .vld_i     (in_vld),
    .pkt_o     (skid_pkt),
    .vld_o     (skid_vld)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_out
    assign pkt_o[i*PKT_W +: PKT_W] = act[i] ? head_pkt[i*PKT_W +: PKT_W] : '0;
  end

  assign up_ready_o   = up_ready_q;
  assign lane_valid_o = head_vld & act & {LANES{dn_valid_o}};

  always_comb begin
    occupancy_o = 2'd0;
    if (!flush_i) begin
      case (state_q)
        HALF:    occupancy_o = 2'd1;
        FULL:    occupancy_o = 2'd2;
        default: occupancy_o = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(up_valid_i && up_ready_q && state_q == FULL));
  end

endmodule

// File: tb/tb_inst_buf_rename_skid.sv
// Directed bench for inst_buf_rename_skid: streaming, backpressure, squash, flush, async reset.
// Lane gating steps run when INST_BUF_REN_LANE_GATE_EN is defined.
module tb_inst_buf_rename_skid;

  localparam int LANES = 4;
  localparam int PKT_W = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush_i;
  logic                   up_valid_i;
  logic                   up_ready_o;
  logic [LANES*PKT_W-1:0] pkt_i;
  logic [LANES-1:0]       lane_valid_i;
  logic                   dn_valid_o;
  logic                   dn_ready_i;
  logic [LANES*PKT_W-1:0] pkt_o;
  logic [LANES-1:0]       lane_valid_o;
  logic [1:0]             occupancy_o;
`ifdef INST_BUF_REN_LANE_GATE_EN
  logic [LANES-1:0]       lane_active_i;
  logic [LANES-1:0]       valid_bundle_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  inst_buf_rename_skid #(.LANES(LANES), .PKT_W(PKT_W), .SQUASH_EMPTY(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .up_valid_i   (up_valid_i),
    .up_ready_o   (up_ready_o),
    .pkt_i        (pkt_i),
    .lane_valid_i (lane_valid_i),
    .dn_valid_o   (dn_valid_o),
    .dn_ready_i   (dn_ready_i),
    .pkt_o        (pkt_o),
    .lane_valid_o (lane_valid_o),
    .occupancy_o  (occupancy_o)
`ifdef INST_BUF_REN_LANE_GATE_EN
    ,
    .lane_active_i  (lane_active_i),
    .valid_bundle_o (valid_bundle_o)
`endif
  );

  function automatic logic [63:0] mk(input logic [7:0] b);
    logic [63:0] r;
    for (int i = 0; i < LANES; i++) r[i*16 +: 16] = {b, 8'(i)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; up_valid_i = 1'b0; dn_ready_i = 1'b0;
    pkt_i = '0; lane_valid_i = '0;
`ifdef INST_BUF_REN_LANE_GATE_EN
    lane_active_i = 4'b1111;
`endif
    #3;
    chk("rst_up_ready", up_ready_o, 1);
    chk("rst_dn_valid", dn_valid_o, 0);
    chk("rst_lane_valid", lane_valid_o, 0);
    chk("rst_pkt", pkt_o, 0);
    chk("rst_occ", occupancy_o, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Streaming A,B,C with rename always ready
    dn_ready_i = 1; up_valid_i = 1; lane_valid_i = 4'b1111; pkt_i = mk(8'hA1);
    tick();
    pkt_i = mk(8'hB2); #1;
    chk("st_a_vld", dn_valid_o, 1);
    chk("st_a_pkt", pkt_o, mk(8'hA1));
    chk("st_a_occ", occupancy_o, 1);
    chk("st_a_rdy", up_ready_o, 1);
    tick();
    pkt_i = mk(8'hC3); #1;
    chk("st_b_pkt", pkt_o, mk(8'hB2));
    chk("st_b_occ", occupancy_o, 1);
    chk("st_b_rdy", up_ready_o, 1);
    tick();
    up_valid_i = 0; #1;
    chk("st_c_pkt", pkt_o, mk(8'hC3));
    chk("st_c_lv", lane_valid_o, 4'b1111);
    tick();
    chk("st_end_vld", dn_valid_o, 0);
    chk("st_end_occ", occupancy_o, 0);
    chk("st_end_lv", lane_valid_o, 0);

    // Backpressure: A then B with rename stalled
    dn_ready_i = 0; up_valid_i = 1; pkt_i = mk(8'hA4);
    tick();
    pkt_i = mk(8'hB5); #1;
    chk("bp_occ1", occupancy_o, 1);
    chk("bp_rdy1", up_ready_o, 1);
    tick();
    up_valid_i = 0; #1;
    chk("bp_occ2", occupancy_o, 2);
    chk("bp_rdy0", up_ready_o, 0);
    chk("bp_head_a", pkt_o, mk(8'hA4));
    dn_ready_i = 1; #1;
    chk("bp_vld", dn_valid_o, 1);
    tick();
    chk("bp_head_b", pkt_o, mk(8'hB5));
    chk("bp_occ_back", occupancy_o, 1);
    chk("bp_rdy_back", up_ready_o, 1);
    tick();
    chk("bp_drained", dn_valid_o, 0);

    // Squash an all-invalid bundle
    dn_ready_i = 0; up_valid_i = 1; lane_valid_i = 4'b0000; pkt_i = mk(8'hD6);
    tick();
    up_valid_i = 0; lane_valid_i = 4'b1111; #1;
    chk("sq_vld", dn_valid_o, 0);
    chk("sq_occ", occupancy_o, 0);
    chk("sq_rdy", up_ready_o, 1);

    // Fill FULL with a partial bundle at head, then flush with both handshakes offered
    up_valid_i = 1; lane_valid_i = 4'b0101; pkt_i = mk(8'hE7);
    tick();
    lane_valid_i = 4'b1111; pkt_i = mk(8'hF8);
    tick();
    up_valid_i = 0; #1;
    chk("fl_full_occ", occupancy_o, 2);
    chk("fl_head_lv", lane_valid_o, 4'b0101);
    flush_i = 1; dn_ready_i = 1; up_valid_i = 1; pkt_i = mk(8'h19); #1;
    chk("fl_vld_low", dn_valid_o, 0);
    chk("fl_lv_low", lane_valid_o, 0);
    chk("fl_occ0", occupancy_o, 0);
    tick();
    flush_i = 0; up_valid_i = 0; #1;
    chk("fl_after_vld", dn_valid_o, 0);
    chk("fl_after_occ", occupancy_o, 0);
    chk("fl_after_rdy", up_ready_o, 1);
    tick();
    chk("fl_no_stale", dn_valid_o, 0);

    // Recovery after flush
    up_valid_i = 1; pkt_i = mk(8'h2A);
    tick();
    up_valid_i = 0; #1;
    chk("rc_pkt", pkt_o, mk(8'h2A));
    tick();

    // Asynchronous reset while FULL
    dn_ready_i = 0; up_valid_i = 1; pkt_i = mk(8'h3B);
    tick();
    pkt_i = mk(8'h4C);
    tick();
    up_valid_i = 0; #1;
    chk("ar_full", occupancy_o, 2);
    reset = 1; #1;
    chk("ar_vld", dn_valid_o, 0);
    chk("ar_occ", occupancy_o, 0);
    chk("ar_rdy", up_ready_o, 1);
    chk("ar_pkt", pkt_o, 0);
    #2 reset = 0;
    tick();

`ifdef INST_BUF_REN_LANE_GATE_EN
    // Only lanes 0-1 active; lane 2 carries a marker that must not reach the output
    begin
      logic [63:0] p;
      p = mk(8'h55);
      p[2*16 +: 16] = 16'hDEAD;
      lane_active_i = 4'b0011; lane_valid_i = 4'b1111; up_valid_i = 1; pkt_i = p; #1;
      chk("lg_vb", valid_bundle_o, 4'b0011);
      tick();
      up_valid_i = 0; #1;
      chk("lg_lv", lane_valid_o, 4'b0011);
      chk("lg_lane2", pkt_o[2*16 +: 16], 0);
      chk("lg_lane0", pkt_o[15:0], 16'h5500);
      lane_active_i = 4'b1111;
      tick();
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_buf_rename_skid.md
Name: inst_buf_rename_skid

Overview:
- Parametrised elastic pipeline stage between the instruction buffer and rename.
- Successor to the fixed single-register stall/flush stage: decouples the upstream stall from downstream ready with a 2-entry skid buffer, so neither side has a combinational ready path.
- Carries LANES packet slots per bundle with per-lane valids and squashes all-invalid bundles.
- Optionally gates inactive lanes for dynamic width configurations.

Parameters:
- LANES, 4, number of lanes per bundle (dispatch width).
- PKT_W, 128, bits per lane packet (rename packet size).
- SQUASH_EMPTY, 1, when 1 a handshaked bundle whose lane valids are all 0 is consumed but not enqueued.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous pipeline flush (exception or mispredict).
- up_valid_i  in  1  upstream bundle valid (instruction buffer ready).
- up_ready_o  out  1  stage can accept a bundle; registered.
- pkt_i  in  LANES*PKT_W  upstream packets; lane i at bits [i*PKT_W +: PKT_W].
- lane_valid_i  in  LANES  per-lane valid of the upstream bundle.
- dn_valid_o  out  1  bundle presented to rename.
- dn_ready_i  in  1  rename accepts the bundle.
- pkt_o  out  LANES*PKT_W  head bundle packets.
- lane_valid_o  out  LANES  head bundle lane valids.
- occupancy_o  out  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (async, active-high): state EMPTY; up_ready_o=1; dn_valid_o=0; lane_valid_o=0; pkt_o=0; occupancy_o=0. Both entries are zeroed.
- Handshakes: upstream fires when up_valid_i & up_ready_o; downstream fires when dn_valid_o & dn_ready_i.
- up_ready_o = (state != FULL), registered. It never depends combinationally on dn_ready_i.
- Output driving: dn_valid_o = (state != EMPTY) & ~flush_i. pkt_o and lane_valid_o come from the head entry register. lane_valid_o is forced 0 when dn_valid_o=0.
- Latency: an accepted bundle is visible at the output on the next cycle (1 cycle). Order is strictly FIFO.
- Enqueue qualifier: enq = upstream fire & (|lane_valid_i | ~SQUASH_EMPTY). A squashed bundle is still consumed upstream.
- EMPTY:
  - enq -> HALF; head loads the input.
- HALF:
  - enq & dn fire -> HALF; head loads the input.
  - enq & ~dn fire -> FULL; skid entry loads the input.
  - ~enq & dn fire -> EMPTY.
  - otherwise -> HALF.
- FULL (up_ready_o=0, so no enq):
  - dn fire -> HALF; head <= skid.
  - otherwise -> FULL.
- Flush: at the next edge, state -> EMPTY, lane valids of both entries cleared, up_ready_o -> 1. Payload need not be cleared.
  - During the flush cycle, upstream and downstream fires are ignored for state update.
  - dn_valid_o is forced low in the same cycle.
- Simultaneous flush and reset: reset wins (asynchronous).
- occupancy_o follows state (EMPTY=0, HALF=1, FULL=2) and is 0 during the flush cycle.
- No overflow is possible. An enq while FULL cannot occur because up_ready_o=0; an assertion fires if up_valid_i & up_ready_o while FULL.
- Payload registers load only on enq or skid-to-head move, to save clock power.

Optional Feature:
- Macro: INST_BUF_REN_LANE_GATE_EN.
- With the macro: adds input lane_active_i [LANES] and output valid_bundle_o [LANES].
  - For lanes with lane_active_i[i]=0: the packet slice is not written, lane_valid_o[i] is forced 0, and pkt_o slice i is forced 0 (isolation emulation).
  - valid_bundle_o[i] = up_valid_i & lane_valid_i[i] & lane_active_i[i], combinational.
  - The squash qualifier uses lane_valid_i & lane_active_i.
- Without the macro: no such ports; all lanes are always active.

Decomposition:
- Shared package (decode pkg): renPkt typedef, REN_PKT_SIZE, DISPATCH_WIDTH; LANES and PKT_W default to these.
- Shared package: state enum skid_state_t {EMPTY, HALF, FULL}.
- One natural sub-module: skid_entry, a PKT_W*LANES+LANES register with load enable and valid clear, instantiated twice (head, skid).

Test Plan:
- Reset mid-stream: assert reset while FULL -> immediately dn_valid_o=0, occupancy_o=0, up_ready_o=1, with no clock edge needed.
- Streaming: dn_ready_i=1; bundles A, B, C on consecutive cycles with lane_valid_i=4'b1111 -> A, B, C appear on cycles +1, +2, +3; occupancy_o stays 1; up_ready_o stays 1.
- Backpressure: dn_ready_i=0; send A then B -> occupancy_o 1 then 2, up_ready_o=0 on the cycle after B. Then raise dn_ready_i -> output A, then B; up_ready_o=1 one cycle after A leaves.
- Squash: SQUASH_EMPTY=1; send a bundle with lane_valid_i=4'b0000 while EMPTY -> up_ready_o stays 1, dn_valid_o stays 0, occupancy_o=0.
- Flush while FULL, with dn_ready_i=1 and up_valid_i=1 in the same cycle -> dn_valid_o=0 that cycle; next cycle state EMPTY, nothing accepted, no stale bundle emitted.
- Lane gating (macro on): lane_active_i=4'b0011, lane_valid_i=4'b1111, lane 2 packet 0xDEAD -> lane_valid_o=4'b0011, pkt_o lane 2 = 0, valid_bundle_o=4'b0011.
